// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: issues MULT/DIV ops, models their
// fixed latency, commits results to HI/LO and drives the pipeline stall request.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   pend_hi_reg, pend_lo_reg;
    logic          pend_valid_reg;
    logic          busy_reg, done_reg;
    logic [31:0]   hi_reg, lo_reg;

    logic          is_md, is_mul, is_signed;
    logic [63:0]   mul_a, mul_b, product;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [31:0]   pend_hi_next, pend_lo_next;
    logic          pend_valid_next;

    assign is_md     = start && (md_op >= 3'd1) && (md_op <= 3'd4);
    assign is_mul    = (md_op == 3'd1) || (md_op == 3'd2);
    assign is_signed = (md_op == 3'd1) || (md_op == 3'd3);

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign mul_a   = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    assign mul_b   = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    assign product = mul_a * mul_b;

    // Signed division on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_neg = is_signed && rs_val[31];
    assign b_neg = is_signed && rt_val[31];
    assign a_mag = a_neg ? (32'd0 - rs_val) : rs_val;
    assign b_mag = b_neg ? (32'd0 - rt_val) : rt_val;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        pend_hi_next    = rem;
        pend_lo_next    = quot;
        pend_valid_next = (rt_val != 32'd0);
        if (is_mul) begin
            pend_hi_next    = product[63:32];
            pend_lo_next    = product[31:0];
            pend_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            pend_hi_reg    <= '0;
            pend_lo_reg    <= '0;
            pend_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (is_md) begin
                        state_reg      <= BUSY;
                        busy_reg       <= 1'b1;
                        count_reg      <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        pend_hi_reg    <= pend_hi_next;
                        pend_lo_reg    <= pend_lo_next;
                        pend_valid_reg <= pend_valid_next;
                    end else if (start && md_op == 3'd5) begin
                        hi_reg <= rs_val;
                    end else if (start && md_op == 3'd6) begin
                        lo_reg <= rs_val;
                    end
                end
                BUSY: begin
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        if (pend_valid_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign stall = d_md_use && (busy_reg || is_md);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, results, stall, ignored starts and reset abort.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        d_md_use = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an issue, checks combinational stall before the edge, then clocks it in.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic exp_stall);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_md_use = use_d;
        #1;
        check("issue_stall", {31'd0, stall}, {31'd0, exp_stall});
        tick();
        start = 1'b0; md_op = 3'd0; rs_val = 32'hdead_beef; rt_val = 32'h0bad_f00d;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic use_d,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b, use_d, use_d);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_stall"}, {31'd0, stall}, {31'd0, use_d});
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
            tick();
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_off"}, {31'd0, stall}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        $display("[TB] %s op=%0d hi=0x%08h lo=0x%08h", tag, op, hi, lo);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        d_md_use = 1'b0;
    endtask

    initial begin
        tick(); tick();
        d_md_use = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0; d_md_use = 1'b0;
        tick();

        run_op("mult_neg", 3'd1, 32'hffff_fffd, 32'd7, 5, 1'b0, 32'hffff_ffff, 32'hffff_ffeb);
        run_op("multu_max", 3'd2, 32'hffff_ffff, 32'hffff_ffff, 5, 1'b0, 32'hffff_fffe, 32'h0000_0001);
        run_op("div_neg", 3'd3, 32'hffff_fff9, 32'd2, 10, 1'b0, 32'hffff_ffff, 32'hffff_fffd);
        run_op("div_negdivisor", 3'd3, 32'd7, 32'hffff_fffe, 10, 1'b0, 32'd1, 32'hffff_fffd);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hffff_ffff, 10, 1'b0, 32'd0, 32'h8000_0000);
        run_op("divu_big", 3'd4, 32'hffff_fff9, 32'd2, 10, 1'b0, 32'd1, 32'h7fff_fffc);

        issue(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_nobusy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        check("mtlo_lo", lo, 32'h22);
        check("mtlo_nodone", {31'd0, done}, 32'd0);
        issue(3'd7, 32'h99, 32'd0, 1'b1, 1'b0);
        check("rsvd_hi", hi, 32'h11);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 1'b0, 32'h11, 32'h22);

        run_op("div_stall", 3'd3, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14);

        // Start during busy is ignored, including one landing on the commit edge.
        issue(3'd3, 32'd100, 32'd9, 1'b1, 1'b1);
        tick();
        start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
        tick();
        start = 1'b0; md_op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            check("overlap_busy", {31'd0, busy}, 32'd1);
            if (i == 7) begin
                start = 1'b1; md_op = 3'd6; rs_val = 32'h55;
            end
            tick();
        end
        start = 1'b0; md_op = 3'd0; d_md_use = 1'b0;
        check("overlap_done", {31'd0, done}, 32'd1);
        check("overlap_hi", hi, 32'd1);
        check("overlap_lo", lo, 32'd11);
        $display("[TB] overlap hi=0x%08h lo=0x%08h", hi, lo);
        tick();
        check("overlap_still_idle", {31'd0, busy}, 32'd0);
        check("overlap_lo_kept", lo, 32'd11);

        // Reset in the third busy cycle of a MULT aborts it.
        issue(3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        tick(); tick();
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        $display("[TB] abort busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
        tick();
        check("abort_no_late_done", {31'd0, done}, 32'd0);
        run_op("mult_after_rst", 3'd1, 32'd6, 32'hffff_fff9, 5, 1'b0, 32'hffff_ffff, 32'hffff_ffd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
